ikaopll_slot_sr: RTL and testbench

- Parametrised, time-division-multiplexed recirculating shift register for the OPLL per-slot state (18 slots by default), clocked by the emulation clock and gated by the chip clock-enable.
- Each enabled cycle the block either loads new data into the head stage or recirculates the tail back to the head.
- Tracks which slot occupies the head stage, re-aligns to an external sync, and flags whether that sync matched its own count.
- Replaces ad-hoc fixed-length per-slot state chains in the operator, envelope and phase paths.

---
 rtl/ikaopll_pkg.sv | 23 ++
 rtl/ikaopll_slot_counter.sv | 60 ++++++
 rtl/ikaopll_slot_sr.sv | 112 +++++++++++
 tb/tb_ikaopll_slot_sr.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ikaopll_pkg.sv
// Shared OPLL definitions: slot count, log2 helper and the slot index type.
package ikaopll_pkg;

    localparam int OPLL_SLOTS = 18;

    // Ceiling log2, never below 1 so a 2-entry ring still gets a 1-bit index.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 1;
        span   = 2;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    localparam int OPLL_SLOT_W = clog2(OPLL_SLOTS);

    typedef logic [OPLL_SLOT_W-1:0] slot_t;

endpackage

// File: rtl/ikaopll_slot_counter.sv
// Modulo-LENGTH slot tracker for the head stage, with sync snap and alignment flag.
module ikaopll_slot_counter
    import ikaopll_pkg::*;
#(
    parameter  int LENGTH = OPLL_SLOTS,
    localparam int SLOT_W = clog2(LENGTH)
) (
    input  logic              i_EMUCLK,
    input  logic              i_RST,
    input  logic              i_CEN_n,
    input  logic              i_SYNC,
    output logic [SLOT_W-1:0] o_SLOT,
    output logic              o_ALIGNED,
    output logic              o_TAIL_SLOT0
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LENGTH - 1);

    logic [SLOT_W-1:0] slot_d;
    logic [SLOT_W-1:0] slot_q;
    logic              aligned_d;
    logic              aligned_q;

    // Next slot and alignment: a sync is "aligned" when we also predicted slot 0.
    always_comb begin
        slot_d    = slot_q;
        aligned_d = aligned_q;
        if (!i_CEN_n) begin
            if (i_SYNC) begin
                slot_d    = {SLOT_W{1'b0}};
                aligned_d = (slot_q == LAST_SLOT);
            end else if (slot_q == LAST_SLOT) begin
                slot_d    = {SLOT_W{1'b0}};
                aligned_d = aligned_q;
            end else begin
                slot_d    = slot_q + SLOT_W'(1);
                aligned_d = aligned_q;
            end
        end else begin
            slot_d    = slot_q;
            aligned_d = aligned_q;
        end
    end

    // Counter state; reset parks at LENGTH-1 so the first written entry is slot 0.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            slot_q    <= LAST_SLOT;
            aligned_q <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            aligned_q <= aligned_d;
        end
    end

    assign o_SLOT       = slot_q;
    assign o_ALIGNED    = aligned_q;
    assign o_TAIL_SLOT0 = (slot_q == LAST_SLOT);

endmodule

// File: rtl/ikaopll_slot_sr.sv
// Recirculating per-slot shift register: load or recirculate into the head each
// enabled cycle, with three parameterised taps and slot tracking.
module ikaopll_slot_sr
    import ikaopll_pkg::*;
#(
    parameter  int               WIDTH  = 1,
    parameter  int               LENGTH = OPLL_SLOTS,
    parameter  int               TAP0   = LENGTH,
    parameter  int               TAP1   = LENGTH,
    parameter  int               TAP2   = LENGTH,
    parameter  logic [WIDTH-1:0] INIT   = '0,
    localparam int               SLOT_W = clog2(LENGTH)
) (
    input  logic              i_EMUCLK,
    input  logic              i_RST,
    input  logic              i_CEN_n,
    input  logic              i_WE,
    input  logic [WIDTH-1:0]  i_D,
    input  logic              i_SYNC,
    output logic [WIDTH-1:0]  o_Q_TAP0,
    output logic [WIDTH-1:0]  o_Q_TAP1,
    output logic [WIDTH-1:0]  o_Q_TAP2,
    output logic [WIDTH-1:0]  o_Q_LAST,
    output logic [SLOT_W-1:0] o_SLOT,
    output logic              o_TAIL_SLOT0,
    output logic              o_ALIGNED
);

    if ((LENGTH < 2) || (TAP0 < 0) || (TAP0 > LENGTH) || (TAP1 < 0) || (TAP1 > LENGTH)
        || (TAP2 < 0) || (TAP2 > LENGTH)) begin : g_bad_params
        $error("ikaopll_slot_sr: illegal LENGTH/TAP parameters");
    end

    logic [WIDTH-1:0] sr_s [LENGTH];
    logic [WIDTH-1:0] hin_s;

    // Head input: fresh data on a write, otherwise the tail wraps around.
    always_comb begin
        hin_s = sr_s[LENGTH-1];
        if (i_WE) begin
            hin_s = i_D;
        end else begin
            hin_s = sr_s[LENGTH-1];
        end
    end

    for (genvar k = 0; k < LENGTH; k++) begin : g_stage
        logic [WIDTH-1:0] stage_in_s;
        logic [WIDTH-1:0] stage_d;
        logic [WIDTH-1:0] stage_q;

        if (k == 0) begin : g_head
            assign stage_in_s = hin_s;
        end else begin : g_body
            assign stage_in_s = sr_s[k-1];
        end

        // Advance only on enabled cycles.
        always_comb begin
            stage_d = stage_q;
            if (!i_CEN_n) begin
                stage_d = stage_in_s;
            end else begin
                stage_d = stage_q;
            end
        end

        // Stage register; reset wins over the clock enable.
        always_ff @(posedge i_EMUCLK) begin
            if (i_RST) begin
                stage_q <= INIT;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign sr_s[k] = stage_q;
    end

    if (TAP0 == 0) begin : g_tap0_hin
        assign o_Q_TAP0 = hin_s;
    end else begin : g_tap0_sr
        assign o_Q_TAP0 = sr_s[TAP0-1];
    end

    if (TAP1 == 0) begin : g_tap1_hin
        assign o_Q_TAP1 = hin_s;
    end else begin : g_tap1_sr
        assign o_Q_TAP1 = sr_s[TAP1-1];
    end

    if (TAP2 == 0) begin : g_tap2_hin
        assign o_Q_TAP2 = hin_s;
    end else begin : g_tap2_sr
        assign o_Q_TAP2 = sr_s[TAP2-1];
    end

    assign o_Q_LAST = sr_s[LENGTH-1];

    ikaopll_slot_counter #(
        .LENGTH (LENGTH)
    ) u_slot_counter (
        .i_EMUCLK     (i_EMUCLK),
        .i_RST        (i_RST),
        .i_CEN_n      (i_CEN_n),
        .i_SYNC       (i_SYNC),
        .o_SLOT       (o_SLOT),
        .o_ALIGNED    (o_ALIGNED),
        .o_TAIL_SLOT0 (o_TAIL_SLOT0)
    );

endmodule

// File: tb/tb_ikaopll_slot_sr.sv
// Bench for ikaopll_slot_sr (LENGTH=18, WIDTH=4, INIT=A, taps 0/1/9): directed
// scenarios plus random traffic against a queue-based reference model.
module tb_ikaopll_slot_sr;
    import ikaopll_pkg::*;

    localparam int          L     = 18;
    localparam logic [3:0]  INITV = 4'hA;

    logic       clk;
    logic       i_RST, i_CEN_n, i_WE, i_SYNC;
    logic [3:0] i_D;
    logic [3:0] o_Q_TAP0, o_Q_TAP1, o_Q_TAP2, o_Q_LAST;
    slot_t      o_SLOT;
    logic       o_TAIL_SLOT0, o_ALIGNED;

    ikaopll_slot_sr #(
        .WIDTH (4), .LENGTH (L), .TAP0 (0), .TAP1 (1), .TAP2 (9), .INIT (INITV)
    ) dut (
        .i_EMUCLK     (clk),
        .i_RST        (i_RST),
        .i_CEN_n      (i_CEN_n),
        .i_WE         (i_WE),
        .i_D          (i_D),
        .i_SYNC       (i_SYNC),
        .o_Q_TAP0     (o_Q_TAP0),
        .o_Q_TAP1     (o_Q_TAP1),
        .o_Q_TAP2     (o_Q_TAP2),
        .o_Q_LAST     (o_Q_LAST),
        .o_SLOT       (o_SLOT),
        .o_TAIL_SLOT0 (o_TAIL_SLOT0),
        .o_ALIGNED    (o_ALIGNED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: m_q[0] is the newest entry, m_q[L-1] the oldest (the tail).
    logic [3:0] m_q[$];
    int         m_slot;
    bit         m_al;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < L; i++) m_q.push_back(INITV);
        m_slot = L - 1;
        m_al   = 1'b0;
    endtask

    task automatic model_edge(input bit we, input logic [3:0] d, input bit sync,
                              input bit cen_n, input bit rst);
        logic [3:0] h;
        if (rst) begin
            model_reset();
        end else if (!cen_n) begin
            h = we ? d : m_q[L-1];
            m_q.push_front(h);
            void'(m_q.pop_back());
            if (sync) begin
                m_al   = (m_slot == L - 1);
                m_slot = 0;
            end else begin
                m_slot = (m_slot + 1) % L;
            end
        end
    endtask

    task automatic check_all();
        chk("tap0", {28'd0, o_Q_TAP0}, {28'd0, (i_WE ? i_D : m_q[L-1])});
        chk("tap1", {28'd0, o_Q_TAP1}, {28'd0, m_q[0]});
        chk("tap2", {28'd0, o_Q_TAP2}, {28'd0, m_q[8]});
        chk("last", {28'd0, o_Q_LAST}, {28'd0, m_q[L-1]});
        chk("slot", 32'(o_SLOT), 32'(m_slot));
        chk("tail_slot0", {31'd0, o_TAIL_SLOT0}, {31'd0, (m_slot == L - 1)});
        chk("aligned", {31'd0, o_ALIGNED}, {31'd0, m_al});
    endtask

    task automatic step(input bit we, input logic [3:0] d, input bit sync,
                        input bit cen_n, input bit rst);
        @(negedge clk);
        i_WE = we; i_D = d; i_SYNC = sync; i_CEN_n = cen_n; i_RST = rst;
        #1;
        chk("tap0_comb", {28'd0, o_Q_TAP0}, {28'd0, (we ? d : m_q[L-1])});
        @(posedge clk);
        model_edge(we, d, sync, cen_n, rst);
        #1;
        check_all();
    endtask

    initial begin
        bit we_r, sync_r, cen_r, rst_r;
        i_RST = 1'b1; i_CEN_n = 1'b1; i_WE = 1'b0; i_SYNC = 1'b0; i_D = 4'h0;

        // Reset with the clock enable inactive.
        @(posedge clk);
        model_reset();
        #1;
        check_all();
        chk("rst_last", {28'd0, o_Q_LAST}, 32'hA);
        chk("rst_slot", 32'(o_SLOT), 32'd17);
        chk("rst_tail", {31'd0, o_TAIL_SLOT0}, 32'd1);
        chk("rst_aligned", {31'd0, o_ALIGNED}, 32'd0);

        // Write slots 0..17 with 0..15,0,1; sync on slot 0.
        for (int i = 0; i < L; i++) step(1'b1, 4'(i % 16), (i == 0), 1'b0, 1'b0);
        chk("wr_aligned", {31'd0, o_ALIGNED}, 32'd1);

        // Recirculate twice through, syncing each frame start.
        for (int i = 0; i < 2 * L; i++) begin
            step(1'b0, 4'($urandom), (m_slot == L - 1), 1'b0, 1'b0);
            chk("recirc_seq", {28'd0, o_Q_LAST}, 32'((i + 1) % L % 16));
            if (o_TAIL_SLOT0) chk("tail_is_slot0", {28'd0, o_Q_LAST}, 32'd0);
        end

        // Alternate gated cycles during recirculation.
        for (int i = 0; i < 2 * L; i++) step(1'b0, 4'($urandom), 1'b0, (i % 2 == 1), 1'b0);

        // Realign, then an early sync, then an on-time sync.
        while (m_slot != L - 1) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("sync_ontime", {31'd0, o_ALIGNED}, 32'd1);
        for (int i = 0; i < 12; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("sync_early_al", {31'd0, o_ALIGNED}, 32'd0);
        chk("sync_early_slot", 32'(o_SLOT), 32'd0);
        for (int i = 0; i < L - 1; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("sync_realigned", {31'd0, o_ALIGNED}, 32'd1);

        // Tap latency for a single written 5.
        for (int i = 0; i < L; i++) step(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
        chk("tap1_lat", {28'd0, o_Q_TAP1}, 32'd5);
        for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("tap2_lat", {28'd0, o_Q_TAP2}, 32'd5);

        // Reset at slot 7 overriding write, sync and enable.
        while (m_slot != 7) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'h3, 1'b1, 1'b0, 1'b1);
        chk("midrst_slot", 32'(o_SLOT), 32'd17);
        chk("midrst_last", {28'd0, o_Q_LAST}, 32'hA);
        chk("midrst_tap1", {28'd0, o_Q_TAP1}, 32'hA);
        chk("midrst_aligned", {31'd0, o_ALIGNED}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            we_r   = ($urandom_range(0, 1) == 1);
            cen_r  = ($urandom_range(0, 3) == 0);
            sync_r = (m_slot == L - 1) ? ($urandom_range(0, 7) != 0)
                                       : ($urandom_range(0, 29) == 0);
            rst_r  = ($urandom_range(0, 99) == 0);
            step(we_r, 4'($urandom), sync_r, cen_r, rst_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
